// File: rtl/datapath_reg_alu_pkg.sv
// ============================================================================
// datapath_reg_alu_pkg : shared widths, depths and ALU opcodes
// Revision 1.0
// ============================================================================
`default_nettype none

package datapath_reg_alu_pkg;

  localparam int DATA_W    = 64;
  localparam int REG_DEPTH = 32;
  localparam int MEM_DEPTH = 256;
  localparam int REG_AW    = 5;
  localparam int MEM_AW    = 8;

  localparam logic [REG_AW-1:0] ZERO_REG = 5'd31;

  // FS[4:2] operation codes
  typedef enum logic [2:0] {
    OP_AND   = 3'b000,
    OP_OR    = 3'b001,
    OP_ADD   = 3'b010,
    OP_XOR   = 3'b011,
    OP_SHL   = 3'b100,
    OP_SHR   = 3'b101,
    OP_ZERO0 = 3'b110,
    OP_ZERO1 = 3'b111
  } alu_op_e;

endpackage

`default_nettype wire

// File: rtl/datapath_reg_alu_alu64.sv
// ============================================================================
// alu64 : 64-bit ALU with operand inversion, carry-in and {V,C,N,Z} flags
// Revision 1.0
// ============================================================================
`default_nettype none

module alu64
  import datapath_reg_alu_pkg::*;
(
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [4:0]        FS,
  output logic [DATA_W-1:0] F,
  output logic [3:0]        status
);

  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W:0]   sum;
  logic              add_sel;
  logic              flag_v;
  logic              flag_c;

  // FS[1]/FS[0] invert the operands; FS[0] doubles as carry-in so A-B is a plain add
  assign op_a = A ^ {DATA_W{FS[1]}};
  assign op_b = B ^ {DATA_W{FS[0]}};
  assign sum  = {1'b0, op_a} + {1'b0, op_b} + {{DATA_W{1'b0}}, FS[0]};

  always_comb begin
    F = '0;
    case (FS[4:2])
      OP_AND:  F = op_a & op_b;
      OP_OR:   F = op_a | op_b;
      OP_ADD:  F = sum[DATA_W-1:0];
      OP_XOR:  F = op_a ^ op_b;
      OP_SHL:  F = op_a << op_b[5:0];
      OP_SHR:  F = op_a >> op_b[5:0];
      default: F = '0;
    endcase
  end

  assign add_sel = (FS[4:2] == OP_ADD);
  assign flag_c  = add_sel & sum[DATA_W];
  assign flag_v  = add_sel & (op_a[DATA_W-1] == op_b[DATA_W-1])
                           & (F[DATA_W-1] != op_a[DATA_W-1]);
  assign status  = {flag_v, flag_c, F[DATA_W-1], (F == '0)};

endmodule

`default_nettype wire

// File: rtl/datapath_reg_alu.sv
// ============================================================================
// datapath_reg_alu : 32x64 register file, 64-bit ALU and 256x64 data memory
// Revision 1.0
// ============================================================================
`default_nettype none

module datapath_reg_alu
  import datapath_reg_alu_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [REG_AW-1:0] DA,
  input  logic [REG_AW-1:0] SA,
  input  logic [REG_AW-1:0] SB,
  input  logic              W,
  input  logic [DATA_W-1:0] K,
  input  logic              BS,
  input  logic [4:0]        FS,
  input  logic              write,
  input  logic              selEN,
  output logic [3:0]        status,
  output logic [DATA_W-1:0] data
);

  logic [DATA_W-1:0] regs [0:REG_DEPTH-1];
  logic [DATA_W-1:0] mem  [0:MEM_DEPTH-1];

  logic [DATA_W-1:0] reg_a;
  logic [DATA_W-1:0] reg_b;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_f;
  logic [DATA_W-1:0] mem_rd;

  // Register 31 is hardwired to zero on the read side and never written
  assign reg_a = (SA == ZERO_REG) ? '0 : regs[SA];
  assign reg_b = (SB == ZERO_REG) ? '0 : regs[SB];
  assign alu_b = BS ? K : reg_b;

  alu64 u_alu (
    .A      (reg_a),
    .B      (alu_b),
    .FS     (FS),
    .F      (alu_f),
    .status (status)
  );

  assign mem_rd = mem[alu_f[MEM_AW-1:0]];
  assign data   = selEN ? alu_f : mem_rd;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REG_DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (W && (DA != ZERO_REG)) begin
      regs[DA] <= data;
    end
  end

  // Data memory keeps its contents across reset; store data is always register B
  always_ff @(posedge clock) begin
    if (write) begin
      mem[alu_f[MEM_AW-1:0]] <= reg_b;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_datapath_reg_alu.sv
// ============================================================================
// tb_datapath_reg_alu : directed vectors checked against a behavioural model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_datapath_reg_alu;

  logic        clk;
  logic        reset;
  logic [4:0]  DA, SA, SB, FS;
  logic        W, BS, write, selEN;
  logic [63:0] K;
  logic [3:0]  status;
  logic [63:0] data;

  int n_cmp  = 0;
  int n_fail = 0;
  bit started = 0;

  datapath_reg_alu dut (
    .clock  (clk),
    .reset  (reset),
    .DA     (DA),
    .SA     (SA),
    .SB     (SB),
    .W      (W),
    .K      (K),
    .BS     (BS),
    .FS     (FS),
    .write  (write),
    .selEN  (selEN),
    .status (status),
    .data   (data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [63:0] mregs [0:31];
  logic [63:0] mmem  [0:255];
  bit          mvalid[0:255];

  function automatic logic [63:0] rd(input logic [4:0] a);
    return (a == 5'd31) ? 64'd0 : mregs[a];
  endfunction

  function automatic void model(output logic [63:0] f, output logic [3:0] st);
    logic [63:0] a, b;
    logic [64:0] usum;
    logic signed [65:0] ssum;
    logic c, v;
    a = rd(SA);
    b = BS ? K : rd(SB);
    if (FS[1]) a = ~a;
    if (FS[0]) b = ~b;
    usum = {1'b0, a} + {1'b0, b} + 65'(FS[0]);
    ssum = $signed({{2{a[63]}}, a}) + $signed({{2{b[63]}}, b}) + 66'(FS[0]);
    c = 1'b0;
    v = 1'b0;
    case (FS[4:2])
      3'd0: f = a & b;
      3'd1: f = a | b;
      3'd2: begin
        f = usum[63:0];
        c = usum[64];
        v = (ssum > 66'sh0_7FFF_FFFF_FFFF_FFFF) || (ssum < -66'sh0_8000_0000_0000_0000);
      end
      3'd3: f = a ^ b;
      3'd4: f = a << b[5:0];
      3'd5: f = a >> b[5:0];
      default: f = 64'd0;
    endcase
    st = {v, c, f[63], f == 64'd0};
  endfunction

  always @(posedge clk) begin
    logic [63:0] f;
    logic [3:0]  st;
    model(f, st);
    if (write) begin
      mmem[f[7:0]]   <= rd(SB);
      mvalid[f[7:0]] <= 1'b1;
    end
  end

  always @(posedge clk or posedge reset) begin
    logic [63:0] f;
    logic [3:0]  st;
    if (reset) begin
      for (int i = 0; i < 32; i++) mregs[i] <= 64'd0;
    end else begin
      model(f, st);
      if (W && DA != 5'd31) mregs[DA] <= selEN ? f : mmem[f[7:0]];
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [63:0] f, exp_d;
    logic [3:0]  st;
    if (started) begin
      model(f, st);
      n_cmp++;
      if (status !== st) begin
        n_fail++;
        $display("FAIL model_status t=%0t got %b want %b", $time, status, st);
      end
      if (selEN || mvalid[f[7:0]]) begin
        exp_d = selEN ? f : mmem[f[7:0]];
        n_cmp++;
        if (data !== exp_d) begin
          n_fail++;
          $display("FAIL model_data t=%0t got %h want %h", $time, data, exp_d);
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic drive(input logic [4:0] da, input logic [4:0] sa, input logic [4:0] sb,
                       input logic w, input logic [63:0] k, input logic bs,
                       input logic [4:0] fs, input logic wr, input logic sel);
    @(posedge clk);
    #1;
    DA = da; SA = sa; SB = sb; W = w; K = k; BS = bs; FS = fs; write = wr; selEN = sel;
  endtask

  task automatic chk_d(input string name, input logic [63:0] want);
    n_cmp++;
    if (data !== want) begin
      n_fail++;
      $display("FAIL %s data got %0d (%h) want %0d (%h)", name, data, data, want, want);
    end
  endtask

  task automatic chk_s(input string name, input logic [3:0] want);
    n_cmp++;
    if (status !== want) begin
      n_fail++;
      $display("FAIL %s status got %b want %b", name, status, want);
    end
  endtask

  task automatic peek(input string name, input logic [4:0] r, input logic [63:0] want);
    drive(5'd0, r, 5'd0, 1'b0, 64'd0, 1'b1, 5'b00100, 1'b0, 1'b1);
    #1 chk_d(name, want);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mmem[i]   = 64'd0;
      mvalid[i] = 1'b0;
    end
    reset = 1'b1;
    DA = 0; SA = 0; SB = 0; W = 0; K = 0; BS = 0; FS = 5'b00100; write = 0; selEN = 0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    started = 1'b1;

    drive(5'd0, 5'd0, 5'd0, 1'b0, 64'd0, 1'b0, 5'b00100, 1'b0, 1'b1);
    #1 chk_s("reset_status", 4'b0001);
    chk_d("reset_data", 64'd0);

    drive(5'd5, 5'd31, 5'd0, 1'b1, 64'd24, 1'b1, 5'b00100, 1'b0, 1'b1);
    #1 chk_d("load_r5_bus", 64'd24);
    drive(5'd7, 5'd31, 5'd0, 1'b1, 64'd39, 1'b1, 5'b00100, 1'b0, 1'b1);
    peek("peek_r5", 5'd5, 64'd24);
    peek("peek_r7", 5'd7, 64'd39);

    drive(5'd1, 5'd5, 5'd7, 1'b1, 64'd0, 1'b0, 5'b01000, 1'b0, 1'b1);
    #1 chk_d("add_r1", 64'd63);
    drive(5'd30, 5'd1, 5'd5, 1'b1, 64'd0, 1'b0, 5'b01100, 1'b0, 1'b1);
    #1 chk_d("xor_r30", 64'd39);
    drive(5'd17, 5'd30, 5'd0, 1'b1, 64'd2, 1'b1, 5'b10000, 1'b0, 1'b1);
    #1 chk_d("shl_r17", 64'd156);
    chk_s("shl_status", 4'b0000);
    drive(5'd0, 5'd1, 5'd5, 1'b0, 64'd0, 1'b0, 5'b00000, 1'b0, 1'b1);
    #1 chk_d("and_r1_r5", 64'd24);
    drive(5'd0, 5'd17, 5'd0, 1'b0, 64'd2, 1'b1, 5'b10100, 1'b0, 1'b1);
    #1 chk_d("shr_r17", 64'd39);
    drive(5'd0, 5'd5, 5'd0, 1'b0, 64'd0, 1'b1, 5'b11000, 1'b0, 1'b1);
    #1 chk_d("op110_zero", 64'd0);
    chk_s("op110_status", 4'b0001);

    // store R17 to M[39], then load it into R0
    drive(5'd0, 5'd7, 5'd17, 1'b0, 64'd0, 1'b1, 5'b00100, 1'b1, 1'b1);
    #1 chk_d("store_addr", 64'd39);
    drive(5'd0, 5'd7, 5'd17, 1'b1, 64'd0, 1'b1, 5'b00100, 1'b0, 1'b0);
    #1 chk_d("load_m39", 64'd156);
    peek("peek_r0", 5'd0, 64'd156);

    // register write and memory write on the same edge
    drive(5'd4, 5'd5, 5'd17, 1'b1, 64'd0, 1'b1, 5'b00100, 1'b1, 1'b1);
    drive(5'd0, 5'd5, 5'd0, 1'b0, 64'd0, 1'b1, 5'b00100, 1'b0, 1'b0);
    #1 chk_d("both_mem24", 64'd156);
    peek("both_r4", 5'd4, 64'd24);

    drive(5'd2, 5'd31, 5'd0, 1'b1, 64'd5, 1'b1, 5'b00100, 1'b0, 1'b1);
    drive(5'd0, 5'd2, 5'd0, 1'b0, 64'd5, 1'b1, 5'b01001, 1'b0, 1'b1);
    #1 chk_d("sub_f", 64'd0);
    chk_s("sub_status", 4'b0101);

    drive(5'd3, 5'd31, 5'd0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 5'b00100, 1'b0, 1'b1);
    drive(5'd0, 5'd3, 5'd0, 1'b0, 64'd1, 1'b1, 5'b01000, 1'b0, 1'b1);
    #1 chk_d("ovf_f", 64'h8000_0000_0000_0000);
    chk_s("ovf_status", 4'b1010);

    drive(5'd31, 5'd31, 5'd0, 1'b1, 64'd24, 1'b1, 5'b00100, 1'b0, 1'b1);
    #1 chk_d("r31_bus", 64'd24);
    peek("r31_zero", 5'd31, 64'd0);

    // asynchronous reset in the middle of a cycle
    peek("pre_reset_r5", 5'd5, 64'd24);
    #1 reset = 1'b1;
    #1 chk_d("async_reset_r5", 64'd0);
    #3 reset = 1'b0;
    peek("post_reset_r7", 5'd7, 64'd0);
    peek("post_reset_r0", 5'd0, 64'd0);
    drive(5'd0, 5'd31, 5'd0, 1'b0, 64'd39, 1'b1, 5'b00100, 1'b0, 1'b0);
    #1 chk_d("mem_retained", 64'd156);

    drive(5'd0, 5'd0, 5'd0, 1'b0, 64'd0, 1'b0, 5'b00100, 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout compared=%0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/datapath_reg_alu.md
DATAPATH_REG_ALU -- requirements
Module: datapath_reg_alu

Interface
REQ-001 Parameters: none; all widths below are fixed.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 DA  input  5  register-file write address.
REQ-005 SA  input  5  register-file read address A, feeding ALU operand A.
REQ-006 SB  input  5  register-file read address B.
REQ-007 W  input  1  register-file write enable.
REQ-008 K  input  64  constant operand.
REQ-009 BS  input  1  operand-B select: 1 = K, 0 = register B.
REQ-010 FS  input  5  ALU function select.
REQ-011 write  input  1  data-memory write enable.
REQ-012 selEN  input  1  data-bus source select: 1 = ALU result, 0 = memory read data.
REQ-013 status  output  4  ALU flags {V,C,N,Z}, bit 3 down to bit 0.
REQ-014 data  output  64  internal data bus, also the register-file write data.

Function
REQ-015 Register file: 32 x 64-bit, two combinational read ports (SA, SB), one write port.
REQ-016 Write: on clock rising edge with W=1, register DA SHALL load data.
REQ-017 Register 31 SHALL always read 0; writes to it SHALL be ignored.
REQ-018 Read-during-write: a read returns the old value until the edge.
REQ-019 Operand A = reg[SA] XOR {64{FS[1]}}.
REQ-020 Operand B = (BS ? K : reg[SB]) XOR {64{FS[0]}}.
REQ-021 Carry-in = FS[0], so FS=01001 computes A-B.
REQ-022 FS[4:2] operation: 000 AND, 001 OR, 010 ADD, 011 XOR, 100 A << B[5:0], 101 A >> B[5:0] (logical), 110/111 result 0.
REQ-023 Flags: Z = (F==0), N = F[63].
REQ-024 C = carry out of bit 63 for ADD, else 0.
REQ-025 V = signed overflow of the ADD (operand signs equal, result sign differs), else 0.
REQ-026 Status SHALL be purely combinational from current inputs and register contents.
REQ-027 Data memory: 256 x 64-bit words, word address = F[7:0] (no byte scaling).
REQ-028 Memory write: on clock rising edge when write=1, mem[F[7:0]] <= reg[SB], regardless of BS.
REQ-029 Memory read: combinational mem[F[7:0]].
REQ-030 data = selEN ? F : memory read data.
REQ-031 W=1 and write=1 in the same cycle SHALL both take effect on that edge.
REQ-032 Latency: one clock edge from inputs to register/memory update; outputs otherwise combinational.

Reset
REQ-033 reset=1 SHALL clear registers 0..30 to 0 immediately, independent of clock; W is ignored while asserted.
REQ-034 Memory SHALL NOT be reset; its contents are retained.
REQ-035 With all registers at 0 and FS=00100, BS=0, status SHALL read 0001.

Structure
REQ-036 Shared package holds the FS[4:2] opcode constants, the 64-bit data width, and the register/memory depths.
REQ-037 The ALU SHALL be one sub-module, alu64 (A, B, FS in; F, status out).
REQ-038 The register file and memory are coded inline in datapath_reg_alu.

Verification
REQ-039 R5 load: SA=31, K=24, BS=1, FS=00100, W=1, DA=5, selEN=1, one edge -> R5=24; then R7=39 likewise.
REQ-040 ADD and XOR: R1<=R5+R7 (FS=01000, BS=0) -> 63; R30<=R1^R5 (FS=01100) -> 39.
REQ-041 Shift: R17<=R30<<2 (FS=10000, K=2, BS=1) -> 156; status N=0, Z=0.
REQ-042 Store then load:
- write=1, SA=7, SB=17, BS=1, K=0, FS=00100 -> M[39]=156.
- Then selEN=0, write=0, W=1, DA=0, same address -> R0=156.
REQ-043 Subtract flags: A=5, B=5 via FS=01001 -> F=0, status 0101 (Z=1, C=1). 0x7FFF...F + 1 with ADD -> V=1, N=1.
REQ-044 Zero register and reset:
- W=1, DA=31 with F=24 -> reg[31] still reads 0.
- Assert reset mid-cycle -> all registers read 0 before the next edge.
